upscale_block: RTL and testbench
================================

Name: upscale_block

Overview:
- Output-side counterpart of the downscale stage in the softmax accelerator.
- Accepts a signed fixed-point (Q7.8 by default) AXI-Stream of per-element results and converts each beat exactly to IEEE-754 FP32.
- Emits the FP32 values on an AXI-Stream master with full backpressure, preserving vector framing (tlast).
- Also tracks vector length, reports completed-vector length, and flags over-length vectors.

Parameters:
- FRAC_W, 8, number of fractional bits in the 16-bit signed input; legal range 0..15.
- C_MAX, 1024, maximum elements per vector.
- ADDR_W, 10, log2(C_MAX); the counter width is ADDR_W+1.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high together with tvalid.
- s_axis_tdata  in  16  signed fixed-point value (two's complement, FRAC_W fractional bits).
- s_axis_tlast  in  1  last element of the vector.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  32  FP32 result.
- m_axis_tlast  out  1  last element of the vector.
- vec_done  out  1  one-cycle pulse when the last beat of a vector completes its output handshake.
- vec_len  out  ADDR_W+1  element count of the most recently completed vector.
- len_err  out  1  sticky flag: a vector exceeded C_MAX elements.

Behaviour:
- Reset (async, while rst=1) drives all outputs and internal state to 0:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, vec_done=0, vec_len=0, len_err=0.
  - All stage valids and the element counter clear; in-flight beats are discarded.
  - s_axis_tready=0 while rst=1.
- Pipeline has 3 register stages:
  - S1 captures the input and computes sign and 16-bit magnitude (-32768 gives magnitude 32768).
  - S2 performs leading-one detect, giving position p in 0..15 plus a zero flag.
  - S3 normalises, packs and registers the output.
- Latency: an accepted beat appears on m_axis_tvalid exactly 3 cycles later when unstalled. Throughput is 1 beat/cycle.
- Stall logic (combinational ready chain):
  - adv3 = m_axis_tready | ~v3
  - adv2 = adv3 | ~v2
  - adv1 = adv2 | ~v1
  - s_axis_tready = adv1 (when not in reset)
  - A stage loads only when its adv is high. No beat is dropped or duplicated under any tready pattern.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
- Conversion is exact; no rounding is needed because magnitude has at most 16 significant bits.
  - Input 0 gives 0x00000000 (+0.0). Negative zero is never produced.
  - Otherwise: sign = input[15]; exponent = 127 + p - FRAC_W; mantissa = the magnitude bits below p, left-aligned into 23 bits, zero-filled.
- Element counter increments on each input handshake and is compared after the increment:
  - On a handshake with s_axis_tlast=1 the counter resets to 0 and the beat is tagged last.
  - If the counter reaches C_MAX without tlast, that beat is force-tagged last, len_err is set, and the counter resets to 0. The next beat starts a new vector.
  - A beat that is both the C_MAX-th and has tlast=1 is a legal vector: len_err stays 0.
- The count of each tagged-last beat travels with it through the pipeline.
- On the output handshake of a tagged-last beat:
  - vec_done pulses high for exactly 1 cycle.
  - vec_len updates to that count in the same cycle and holds until the next update.
- len_err is cleared only by rst.
- Reset mid-vector: partial vector state is lost, and the first beat after reset starts count 1.

Test Plan:
- Beats 0x0100, 0xFF00, 0x0080, 0x0001 (tlast on the last), m_axis_tready=1 -> outputs 0x3F800000, 0xBF800000, 0x3F000000, 0x3B800000, each 3 cycles after its input. tlast is on the 4th output only, then vec_done=1 for one cycle and vec_len=4.
- Boundary values: 0x7FFF -> 0x42FFFE00; 0x8000 -> 0xC3000000; 0xFFFF -> 0xBB800000; 0x0000 -> 0x00000000.
- Backpressure: stream 16 consecutive values with m_axis_tready toggled randomly (including 5-cycle low runs) -> the output sequence is identical and in order. tdata is stable during every stall. s_axis_tready drops only once all 3 stages are full.
- Over-length: C_MAX=8, send 10 beats with tlast only on beat 10 -> output beat 8 has tlast=1, len_err=1, vec_len=8. Beat 10 has tlast=1 and vec_len=2. len_err stays 1.
- Exact length: C_MAX=8, 8 beats with tlast on beat 8 -> len_err=0, vec_len=8.
- Reset mid-stream: assert rst while 3 beats are in flight -> m_axis_tvalid=0 immediately and no stale beat appears. After release, a 2-beat vector yields vec_len=2.

Source files
------------

// File: rtl/upscale_block.sv
// upscale_block: signed fixed-point to IEEE-754 FP32 stream converter.
// Three-stage pipeline with full backpressure, vector framing and length tracking.
module upscale_block #(
  parameter int FRAC_W = 8,
  parameter int C_MAX  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [15:0]       s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              vec_done,
  output logic [ADDR_W:0]   vec_len,
  output logic              len_err
);

  localparam int CW = ADDR_W + 1;

  logic          v1, v2, v3;
  logic          adv1, adv2, adv3;
  logic          hs_in;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          at_max;
  logic          tag_last;

  logic          sign1;
  logic [15:0]   mag1;
  logic          last1;
  logic [CW-1:0] len1;

  logic          sign2;
  logic [15:0]   mag2;
  logic [3:0]    p2;
  logic          zero2;
  logic          last2;
  logic [CW-1:0] len2;

  logic [CW-1:0] len3;

  logic [3:0]    p_c;
  logic [7:0]    exp_c;
  logic [22:0]   mant_c;
  logic [31:0]   word_c;

  // Ready chain: a stage may load when the one after it can take its beat.
  always_comb begin
    adv3 = m_axis_tready | ~v3;
    adv2 = adv3 | ~v2;
    adv1 = adv2 | ~v1;
  end

  assign s_axis_tready = adv1 & ~rst;
  assign hs_in         = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = v3;

  // Element count after this beat; the C_MAX-th beat closes the vector.
  always_comb begin
    cnt_nxt  = cnt + 1'b1;
    at_max   = (cnt_nxt == CW'(C_MAX));
    tag_last = s_axis_tlast | at_max;
  end

  // Vector element counter and sticky over-length flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      len_err <= 1'b0;
    end else if (hs_in) begin
      cnt <= tag_last ? '0 : cnt_nxt;
      if (at_max && !s_axis_tlast)
        len_err <= 1'b1;
    end
  end

  // S1: capture beat, split into sign and magnitude.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      mag1  <= '0;
      last1 <= 1'b0;
      len1  <= '0;
    end else if (adv1) begin
      v1    <= hs_in;
      sign1 <= s_axis_tdata[15];
      mag1  <= s_axis_tdata[15] ? (~s_axis_tdata + 16'd1)
                                : s_axis_tdata;
      last1 <= tag_last;
      len1  <= cnt_nxt;
    end
  end

  // Leading-one position of the S1 magnitude.
  always_comb begin
    p_c = 4'd0;
    for (int i = 0; i < 16; i++)
      if (mag1[i])
        p_c = 4'(i);
  end

  // S2: register leading-one position and zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      mag2  <= '0;
      p2    <= '0;
      zero2 <= 1'b0;
      last2 <= 1'b0;
      len2  <= '0;
    end else if (adv2) begin
      v2    <= v1;
      sign2 <= sign1;
      mag2  <= mag1;
      p2    <= p_c;
      zero2 <= (mag1 == 16'd0);
      last2 <= last1;
      len2  <= len1;
    end
  end

  // Normalise and pack; shifting right by p leaves the bits below
  // the leading one left-aligned in the low 23 bits.
  always_comb begin
    exp_c  = 8'd127 + 8'(p2) - 8'(FRAC_W);
    mant_c = 23'({mag2, 23'd0} >> p2);
    word_c = zero2 ? 32'd0 : {sign2, exp_c, mant_c};
  end

  // S3: output register, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3           <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      len3         <= '0;
    end else if (adv3) begin
      v3           <= v2;
      m_axis_tdata <= word_c;
      m_axis_tlast <= last2;
      len3         <= len2;
    end
  end

  // Report completed vectors on the output handshake of a last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_done <= 1'b0;
      vec_len  <= '0;
    end else begin
      vec_done <= v3 & m_axis_tready & m_axis_tlast;
      if (v3 && m_axis_tready && m_axis_tlast)
        vec_len <= len3;
    end
  end

endmodule

// File: tb/tb_upscale_block.sv
// tb_upscale_block: scoreboard bench for upscale_block.
// Small C_MAX so over-length and exact-length framing are reachable.
module tb_upscale_block;

  localparam int FRAC_W = 8;
  localparam int C_MAX  = 8;
  localparam int ADDR_W = 3;
  localparam int LW     = ADDR_W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [15:0]   s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic          m_last;
  logic          vec_done;
  logic [LW-1:0] vec_len;
  logic          len_err;

  upscale_block #(
    .FRAC_W (FRAC_W),
    .C_MAX  (C_MAX),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .vec_done      (vec_done),
    .vec_len       (vec_len),
    .len_err       (len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   d;
    logic          l;
    logic [LW-1:0] len;
    int            cyc;
    logic          lat;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            mcnt = 0;
  int            rdy_mode = 0;
  logic          lat_on = 1'b1;
  logic          pend = 1'b0;
  logic [LW-1:0] pend_len = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fp32(input logic [15:0] x);
    longint v, mag;
    int p;
    logic [7:0] e;
    logic [22:0] m;
    v = longint'($signed(x));
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 16; i++)
      if (((mag >> i) & 1) == 1) p = i;
    e = 8'(127 + p - FRAC_W);
    m = 23'((mag - (longint'(1) << p)) << (23 - p));
    return {x[15], e, m};
  endfunction

  // Downstream ready: 0 always on, 1 random with 5-cycle low runs, 2 held low.
  initial begin
    int low;
    low = 0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: m_ready = 1'b1;
        2: m_ready = 1'b0;
        default: begin
          if (low > 0) begin
            m_ready = 1'b0;
            low--;
          end else if ($urandom_range(0, 7) == 0) begin
            low = 4;
            m_ready = 1'b0;
          end else begin
            m_ready = 1'($urandom_range(0, 1));
          end
        end
      endcase
    end
  end

  task automatic send(input logic [15:0] x, input logic tl,
                      input logic [31:0] xd);
    int w;
    logic acc;
    exp_t e;
    w = 0;
    acc = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = x;
    s_last = tl;
    while (!acc) begin
      #1;
      if (s_ready) begin
        mcnt++;
        e.d = xd;
        e.l = tl || (mcnt == C_MAX);
        e.len = LW'(mcnt);
        e.cyc = cyc;
        e.lat = lat_on;
        sb.push_back(e);
        if (e.l) mcnt = 0;
        acc = 1'b1;
      end else begin
        w++;
        if (w > 200) begin
          check_eq("send_timeout", 0, 1);
          acc = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || pend) && w < 300) begin
      @(negedge clk);
      #3;
      w++;
    end
    if (w >= 300) check_eq("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
    #3;
  endtask

  // Output monitor: scoreboard pop, stall stability, vec_done timing.
  initial begin
    logic ps;
    logic [31:0] pd;
    logic pl;
    exp_t e;
    ps = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pend = 1'b0;
        ps = 1'b0;
      end else begin
        if (pend) begin
          check_eq("vec_done", 64'(vec_done), 1);
          check_eq("vec_len", 64'(vec_len), 64'(pend_len));
          pend = 1'b0;
        end else begin
          check_eq("vec_done_idle", 64'(vec_done), 0);
        end
        if (ps) begin
          check_eq("stall_valid", 64'(m_valid), 1);
          check_eq("stall_data", {m_data, m_last}, {pd, pl});
        end
        if (!s_ready)
          check_eq("tready_drop", {m_valid, m_ready}, 2'b10);
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_beat", 64'(m_data), 64'hdead);
          end else begin
            e = sb.pop_front();
            check_eq("data", 64'(m_data), 64'(e.d));
            check_eq("last", 64'(m_last), 64'(e.l));
            if (e.lat)
              check_eq("latency", 64'(cyc - e.cyc), 3);
            if (e.l) begin
              pend = 1'b1;
              pend_len = e.len;
            end
          end
        end
        ps = m_valid && !m_ready;
        pd = m_data;
        pl = m_last;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    rdy_mode = 0;
    lat_on = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check_eq("rst_m_valid", 64'(m_valid), 0);
    check_eq("rst_m_data", 64'(m_data), 0);
    check_eq("rst_m_last", 64'(m_last), 0);
    check_eq("rst_vec_done", 64'(vec_done), 0);
    check_eq("rst_vec_len", 64'(vec_len), 0);
    check_eq("rst_len_err", 64'(len_err), 0);
    check_eq("rst_s_ready", 64'(s_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    send(16'h0100, 1'b0, 32'h3F800000);
    send(16'hFF00, 1'b0, 32'hBF800000);
    send(16'h0080, 1'b0, 32'h3F000000);
    send(16'h0001, 1'b1, 32'h3B800000);
    drain();
    check_eq("t1_vec_len", 64'(vec_len), 4);

    send(16'h7FFF, 1'b0, 32'h42FFFE00);
    send(16'h8000, 1'b0, 32'hC3000000);
    send(16'hFFFF, 1'b0, 32'hBB800000);
    send(16'h0000, 1'b1, 32'h00000000);
    drain();

    for (int i = 0; i < 8; i++) begin
      r = 16'($urandom);
      send(r, i == 7, fp32(r));
    end
    drain();
    check_eq("exact_len_err", 64'(len_err), 0);
    check_eq("exact_vec_len", 64'(vec_len), 8);

    rdy_mode = 1;
    lat_on = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r = 16'($urandom);
      send(r, (i % 8) == 7, fp32(r));
    end
    drain();
    rdy_mode = 0;
    lat_on = 1'b1;

    for (int i = 0; i < 10; i++) begin
      r = 16'($urandom);
      send(r, i == 9, fp32(r));
    end
    drain();
    check_eq("over_len_err", 64'(len_err), 1);
    check_eq("over_vec_len", 64'(vec_len), 2);

    rdy_mode = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      r = 16'($urandom);
      send(r, 1'b0, fp32(r));
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_m_valid", 64'(m_valid), 0);
    check_eq("mid_rst_s_ready", 64'(s_ready), 0);
    check_eq("mid_rst_len_err", 64'(len_err), 0);
    sb.delete();
    mcnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    send(16'h0200, 1'b0, 32'h40000000);
    send(16'hFE00, 1'b1, 32'hC0000000);
    drain();
    check_eq("post_rst_vec_len", 64'(vec_len), 2);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
